// File: rtl/rca_writeback_buffer.sv
// Writeback buffer between RCA units and the CPU writeback port: per-unit FIFOs,
// round-robin arbitration, and serialisation of each instruction into per-register beats.
module rca_writeback_buffer #(
    parameter int XLEN            = 32,
    parameter int NUM_RCAS        = 2,
    parameter int NUM_WRITE_PORTS = 2,
    parameter int FIFO_DEPTH      = 4,
    parameter int ID_W            = 3,
    localparam int PIDX_W = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     flush,
    input  logic [NUM_RCAS-1:0]                      rca_done,
    input  logic [NUM_RCAS*ID_W-1:0]                 rca_id,
    input  logic [NUM_RCAS*NUM_WRITE_PORTS*XLEN-1:0] rca_rd,
    input  logic [NUM_RCAS*NUM_WRITE_PORTS-1:0]      rca_rd_valid,
    output logic [NUM_RCAS-1:0]                      rca_ack,
    output logic [NUM_RCAS-1:0]                      rca_fifo_full,
    output logic                                     wb_done,
    output logic [ID_W-1:0]                          wb_id,
    output logic [XLEN-1:0]                          wb_data,
    output logic [PIDX_W-1:0]                        wb_port_idx,
    output logic                                     wb_we,
    output logic                                     wb_last,
    input  logic                                     wb_ack
);

    localparam int NWP   = NUM_WRITE_PORTS;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1;

    typedef logic [NWP-1:0] mask_t;
    typedef logic [NWP-1:0][XLEN-1:0] data_t;
    typedef enum logic {IDLE, SEND} state_t;

    localparam mask_t            MASK_ONE = mask_t'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [RR_W-1:0]  RR_ONE   = RR_W'(1);
    localparam logic [RR_W-1:0]  RR_LAST  = RR_W'(NUM_RCAS - 1);

    logic [ID_W-1:0]  inId   [NUM_RCAS];
    mask_t            inMask [NUM_RCAS];
    data_t            inData [NUM_RCAS];

    logic [ID_W-1:0]  idMem_q   [NUM_RCAS][FIFO_DEPTH];
    mask_t            maskMem_q [NUM_RCAS][FIFO_DEPTH];
    data_t            dataMem_q [NUM_RCAS][FIFO_DEPTH];
    logic [PTR_W-1:0] head_q    [NUM_RCAS];
    logic [PTR_W-1:0] tail_q    [NUM_RCAS];
    logic [CNT_W-1:0] count_q   [NUM_RCAS];

    state_t           state_q;
    logic [ID_W-1:0]  holdId_q;
    mask_t            holdMask_q;
    data_t            holdData_q;
    logic [RR_W-1:0]  rr_q;

    logic [NUM_RCAS-1:0] avail;
    logic [NUM_RCAS-1:0] pop;
    logic                anyAvail;
    logic                found;
    logic [RR_W-1:0]     grant;
    logic [RR_W-1:0]     cand;
    logic [PTR_W-1:0]    headPtr;
    logic [ID_W-1:0]     loadId;
    mask_t               loadMask;
    data_t               loadData;
    logic                load;
    logic [PIDX_W-1:0]   idx;
    logic                beatLast;
    logic                send;

    always_comb begin
        for (int i = 0; i < NUM_RCAS; i++) begin
            inId[i]          = rca_id[i*ID_W +: ID_W];
            inMask[i]        = rca_rd_valid[i*NWP +: NWP];
            inData[i]        = rca_rd[i*NWP*XLEN +: NWP*XLEN];
            rca_fifo_full[i] = (count_q[i] == CNT_FULL);
            rca_ack[i]       = rca_done[i] & (count_q[i] != CNT_FULL) & ~flush & ~rst;
        end
    end

    // A delivery accepted this cycle is already eligible for the grant, so an idle
    // block produces its first beat on the very next cycle.
    always_comb begin
        for (int i = 0; i < NUM_RCAS; i++) begin
            avail[i] = (count_q[i] != '0) | rca_ack[i];
        end
    end

    always_comb begin
        grant = '0;
        cand  = '0;
        found = 1'b0;
        for (int off = 0; off < NUM_RCAS; off++) begin
            cand = RR_W'((int'(rr_q) + off) % NUM_RCAS);
            if (!found && avail[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
        anyAvail = |avail;
        headPtr  = head_q[grant];
        if (count_q[grant] != '0) begin
            loadId   = idMem_q[grant][headPtr];
            loadMask = maskMem_q[grant][headPtr];
            loadData = dataMem_q[grant][headPtr];
        end else begin
            loadId   = inId[grant];
            loadMask = inMask[grant];
            loadData = inData[grant];
        end
    end

    assign load = ~flush & anyAvail & ((state_q == IDLE) | (wb_ack & beatLast));

    always_comb begin
        for (int i = 0; i < NUM_RCAS; i++) begin
            pop[i] = load & (grant == RR_W'(i));
        end
    end

    // Beat decode: the lowest remaining mask bit is the slot written this cycle.
    always_comb begin
        idx = '0;
        for (int j = NWP - 1; j >= 0; j--) begin
            if (holdMask_q[j]) idx = PIDX_W'(j);
        end
        beatLast    = ((holdMask_q & (holdMask_q - MASK_ONE)) == '0);
        send        = (state_q == SEND);
        wb_done     = send;
        wb_id       = send ? holdId_q : '0;
        wb_we       = send & (holdMask_q != '0);
        wb_port_idx = wb_we ? idx : '0;
        wb_data     = wb_we ? holdData_q[idx] : '0;
        wb_last     = send & beatLast;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_RCAS; i++) begin
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
                count_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < NUM_RCAS; i++) begin
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
                count_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RCAS; i++) begin
                if (rca_ack[i]) tail_q[i] <= tail_q[i] + PTR_ONE;
                if (pop[i])     head_q[i] <= head_q[i] + PTR_ONE;
                if (rca_ack[i] && !pop[i]) begin
                    count_q[i] <= count_q[i] + CNT_ONE;
                end else if (pop[i] && !rca_ack[i]) begin
                    count_q[i] <= count_q[i] - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_RCAS; i++) begin
            if (rca_ack[i]) begin
                idMem_q[i][tail_q[i]]   <= inId[i];
                maskMem_q[i][tail_q[i]] <= inMask[i];
                dataMem_q[i][tail_q[i]] <= inData[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            holdId_q   <= '0;
            holdMask_q <= '0;
            holdData_q <= '0;
            rr_q       <= '0;
        end else if (flush) begin
            state_q <= IDLE;
        end else if (load) begin
            state_q    <= SEND;
            holdId_q   <= loadId;
            holdMask_q <= loadMask;
            holdData_q <= loadData;
            rr_q       <= (grant == RR_LAST) ? '0 : grant + RR_ONE;
        end else if (state_q == SEND && wb_ack) begin
            if (beatLast) begin
                state_q <= IDLE;
            end else begin
                holdMask_q <= holdMask_q & (holdMask_q - MASK_ONE);
            end
        end
    end

endmodule

// File: tb/tb_rca_writeback_buffer.sv
// Self-checking bench for rca_writeback_buffer: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_rca_writeback_buffer;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [1:0]   rca_done;
    logic [5:0]   rca_id;
    logic [127:0] rca_rd;
    logic [3:0]   rca_rd_valid;
    logic [1:0]   rca_ack;
    logic [1:0]   rca_fifo_full;
    logic         wb_done;
    logic [2:0]   wb_id;
    logic [31:0]  wb_data;
    logic [0:0]   wb_port_idx;
    logic         wb_we;
    logic         wb_last;
    logic         wb_ack;

    logic [38:0]  beat;
    int           checks;
    int           errors;

    typedef struct packed {
        logic [2:0]  id;
        logic [1:0]  mask;
        logic [31:0] d1;
        logic [31:0] d0;
    } entry_t;

    rca_writeback_buffer #(
        .XLEN(32), .NUM_RCAS(2), .NUM_WRITE_PORTS(2), .FIFO_DEPTH(4), .ID_W(3)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .rca_done(rca_done), .rca_id(rca_id), .rca_rd(rca_rd), .rca_rd_valid(rca_rd_valid),
        .rca_ack(rca_ack), .rca_fifo_full(rca_fifo_full),
        .wb_done(wb_done), .wb_id(wb_id), .wb_data(wb_data), .wb_port_idx(wb_port_idx),
        .wb_we(wb_we), .wb_last(wb_last), .wb_ack(wb_ack)
    );

    assign beat = {wb_done, wb_id, wb_port_idx, wb_we, wb_last, wb_data};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs an expected writeback beat in the same order as 'beat'.
    function automatic logic [38:0] mk(input logic d, input logic [2:0] id, input logic p,
                                       input logic we, input logic last, input logic [31:0] data);
        return {d, id, p, we, last, data};
    endfunction

    task automatic setUnit(input int u, input logic d, input logic [2:0] id, input logic [1:0] m,
                           input logic [31:0] d0, input logic [31:0] d1);
        rca_done[u]             = d;
        rca_id[u*3 +: 3]        = id;
        rca_rd_valid[u*2 +: 2]  = m;
        rca_rd[(u*2)*32 +: 32]  = d0;
        rca_rd[(u*2+1)*32 +: 32] = d1;
    endtask

    task automatic doReset();
        rst = 1'b1; flush = 1'b0; wb_ack = 1'b0;
        rca_done = '0; rca_id = '0; rca_rd = '0; rca_rd_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; wb_ack = 1'b1;
        setUnit(0, 1'b1, 3'd1, 2'b11, 32'h1, 32'h2);
        setUnit(1, 1'b1, 3'd2, 2'b01, 32'h3, 32'h4);
        @(negedge clk);
        #1;
        checks++;
        if (beat !== 39'd0) begin
            errors++;
            $display("[TB] FAIL reset_wb: got %h expected %h", beat, 39'd0);
        end
        checks++;
        if ({rca_ack, rca_fifo_full} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ack_full: got %b expected %b", {rca_ack, rca_fifo_full}, 4'b0000);
        end
        @(negedge clk);
        rst = 1'b0; wb_ack = 1'b0;
        setUnit(0, 1'b0, 3'd0, 2'b00, 32'h0, 32'h0);
        setUnit(1, 1'b0, 3'd0, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic test_single();
        doReset();
        wb_ack = 1'b1;
        setUnit(0, 1'b1, 3'd3, 2'b11, 32'hA, 32'hB);
        #1;
        checks++;
        if ({rca_ack, wb_done} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL single_accept: got %b expected %b", {rca_ack, wb_done}, 3'b010);
        end
        @(negedge clk);
        setUnit(0, 1'b0, 3'd0, 2'b00, 32'h0, 32'h0);
        #1;
        checks++;
        if (beat !== mk(1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 32'hA)) begin
            errors++;
            $display("[TB] FAIL single_beat0: got %h expected %h", beat, mk(1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 32'hA));
        end
        @(negedge clk);
        #1;
        checks++;
        if (beat !== mk(1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 32'hB)) begin
            errors++;
            $display("[TB] FAIL single_beat1: got %h expected %h", beat, mk(1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 32'hB));
        end
        @(negedge clk);
        #1;
        checks++;
        if (wb_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_idle: got %b expected 0", wb_done);
        end
        @(negedge clk);
    endtask

    task automatic test_masks();
        wb_ack = 1'b1;
        setUnit(0, 1'b1, 3'd5, 2'b10, 32'h11, 32'h22);
        @(negedge clk);
        setUnit(0, 1'b0, 3'd0, 2'b00, 32'h0, 32'h0);
        #1;
        checks++;
        if (beat !== mk(1'b1, 3'd5, 1'b1, 1'b1, 1'b1, 32'h22)) begin
            errors++;
            $display("[TB] FAIL sparse_mask: got %h expected %h", beat, mk(1'b1, 3'd5, 1'b1, 1'b1, 1'b1, 32'h22));
        end
        @(negedge clk);
        setUnit(0, 1'b1, 3'd6, 2'b00, 32'h33, 32'h44);
        #1;
        checks++;
        if (wb_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sparse_single_beat: got %b expected 0", wb_done);
        end
        @(negedge clk);
        setUnit(0, 1'b0, 3'd0, 2'b00, 32'h0, 32'h0);
        #1;
        checks++;
        if (beat !== mk(1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 32'h0)) begin
            errors++;
            $display("[TB] FAIL empty_mask: got %h expected %h", beat, mk(1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 32'h0));
        end
        @(negedge clk);
        #1;
        checks++;
        if (wb_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL empty_single_beat: got %b expected 0", wb_done);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [31:0] expData;
        doReset();
        wb_ack = 1'b1;
        for (int c = 0; c < 10; c++) begin
            setUnit(0, 1'b1, 3'(c), 2'b01, {16'h0000, 16'(c)}, 32'h0);
            setUnit(1, 1'b1, 3'(c), 2'b01, {16'h0001, 16'(c)}, 32'h0);
            #1;
            if (c == 0) begin
                checks++;
                if ({rca_ack, wb_done} !== 3'b110) begin
                    errors++;
                    $display("[TB] FAIL rr_first: got %b expected %b", {rca_ack, wb_done}, 3'b110);
                end
            end else begin
                expData = {16'((c - 1) % 2), 16'((c - 1) / 2)};
                checks++;
                if ({wb_done, wb_data} !== {1'b1, expData}) begin
                    errors++;
                    $display("[TB] FAIL rr_order cycle %0d: got %b/%h expected 1/%h", c, wb_done, wb_data, expData);
                end
            end
            @(negedge clk);
        end
        setUnit(0, 1'b0, 3'd0, 2'b00, 32'h0, 32'h0);
        setUnit(1, 1'b0, 3'd0, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic test_full_backpressure();
        logic [3:0] expAF;
        logic [31:0] expD;
        doReset();
        wb_ack = 1'b0;
        setUnit(1, 1'b1, 3'd7, 2'b11, 32'h111, 32'h222);
        #1;
        checks++;
        if (rca_ack !== 2'b10) begin
            errors++;
            $display("[TB] FAIL bp_busy_accept: got %b expected 10", rca_ack);
        end
        @(negedge clk);
        setUnit(1, 1'b0, 3'd0, 2'b00, 32'h0, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            setUnit(0, 1'b1, 3'(k - 1), 2'b01, 32'h100 + 32'(k - 1), 32'h0);
            #1;
            expAF = {(k <= 4) ? 2'b01 : 2'b00, (k == 5) ? 2'b01 : 2'b00};
            checks++;
            if ({rca_ack, rca_fifo_full} !== expAF) begin
                errors++;
                $display("[TB] FAIL bp_fill %0d: got %b expected %b", k, {rca_ack, rca_fifo_full}, expAF);
            end
            checks++;
            if (beat !== mk(1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 32'h111)) begin
                errors++;
                $display("[TB] FAIL bp_stall_stable %0d: got %h expected %h", k, beat, mk(1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 32'h111));
            end
            @(negedge clk);
        end
        setUnit(0, 1'b0, 3'd0, 2'b00, 32'h0, 32'h0);
        wb_ack = 1'b1;
        #1;
        checks++;
        if ({rca_fifo_full, beat} !== {2'b01, mk(1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 32'h111)}) begin
            errors++;
            $display("[TB] FAIL bp_release: got %b/%h expected 01/%h", rca_fifo_full, beat, mk(1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 32'h111));
        end
        @(negedge clk);
        #1;
        checks++;
        if (beat !== mk(1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 32'h222)) begin
            errors++;
            $display("[TB] FAIL bp_second_beat: got %h expected %h", beat, mk(1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 32'h222));
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            #1;
            expD = 32'h100 + 32'(k);
            checks++;
            if (beat !== mk(1'b1, 3'(k), 1'b0, 1'b1, 1'b1, expD)) begin
                errors++;
                $display("[TB] FAIL bp_drain %0d: got %h expected %h", k, beat, mk(1'b1, 3'(k), 1'b0, 1'b1, 1'b1, expD));
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if ({wb_done, rca_fifo_full} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL bp_drained: got %b expected 000", {wb_done, rca_fifo_full});
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        doReset();
        wb_ack = 1'b0;
        setUnit(1, 1'b1, 3'd7, 2'b11, 32'h777, 32'h888);
        @(negedge clk);
        setUnit(1, 1'b0, 3'd0, 2'b00, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            setUnit(0, 1'b1, 3'(k), 2'b01, 32'h200 + 32'(k), 32'h0);
            @(negedge clk);
        end
        setUnit(0, 1'b1, 3'd5, 2'b01, 32'h55, 32'h0);
        flush = 1'b1;
        #1;
        checks++;
        if ({rca_ack, wb_done} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL flush_refuse: got %b expected 001", {rca_ack, wb_done});
        end
        @(negedge clk);
        flush = 1'b0;
        setUnit(0, 1'b0, 3'd0, 2'b00, 32'h0, 32'h0);
        #1;
        checks++;
        if ({beat, rca_fifo_full} !== 41'd0) begin
            errors++;
            $display("[TB] FAIL flush_clear: got %h/%b expected 0/00", beat, rca_fifo_full);
        end
        wb_ack = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (wb_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_empty: got %b expected 0", wb_done);
        end
        setUnit(0, 1'b1, 3'd6, 2'b01, 32'h66, 32'h0);
        @(negedge clk);
        setUnit(0, 1'b0, 3'd0, 2'b00, 32'h0, 32'h0);
        #1;
        checks++;
        if (beat !== mk(1'b1, 3'd6, 1'b0, 1'b1, 1'b1, 32'h66)) begin
            errors++;
            $display("[TB] FAIL flush_recover: got %h expected %h", beat, mk(1'b1, 3'd6, 1'b0, 1'b1, 1'b1, 32'h66));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        doReset();
        wb_ack = 1'b0;
        setUnit(0, 1'b1, 3'd2, 2'b11, 32'hAA, 32'hBB);
        @(negedge clk);
        setUnit(1, 1'b1, 3'd3, 2'b01, 32'hCC, 32'h0);
        #1;
        checks++;
        if (wb_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_busy: got %b expected 1", wb_done);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({beat, rca_ack, rca_fifo_full} !== 43'd0) begin
            errors++;
            $display("[TB] FAIL midrst_async: got %h/%b/%b expected 0", beat, rca_ack, rca_fifo_full);
        end
        @(negedge clk);
        rst = 1'b0;
        wb_ack = 1'b1;
        setUnit(0, 1'b1, 3'd4, 2'b01, 32'h40, 32'h0);
        setUnit(1, 1'b1, 3'd5, 2'b01, 32'h50, 32'h0);
        #1;
        checks++;
        if ({rca_ack, wb_done} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL midrst_accept: got %b expected 110", {rca_ack, wb_done});
        end
        @(negedge clk);
        setUnit(0, 1'b0, 3'd0, 2'b00, 32'h0, 32'h0);
        setUnit(1, 1'b0, 3'd0, 2'b00, 32'h0, 32'h0);
        #1;
        checks++;
        if (beat !== mk(1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 32'h40)) begin
            errors++;
            $display("[TB] FAIL midrst_grant_u0: got %h expected %h", beat, mk(1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 32'h40));
        end
        @(negedge clk);
        #1;
        checks++;
        if (beat !== mk(1'b1, 3'd5, 1'b0, 1'b1, 1'b1, 32'h50)) begin
            errors++;
            $display("[TB] FAIL midrst_grant_u1: got %h expected %h", beat, mk(1'b1, 3'd5, 1'b0, 1'b1, 1'b1, 32'h50));
        end
        @(negedge clk);
    endtask

    // Reference model: one queue per unit holding whole instructions, the instruction
    // currently being written back, and the set of its slots still to be written.
    task automatic test_random();
        entry_t      mq[2][$];
        entry_t      cur;
        entry_t      e;
        logic        busy;
        logic [1:0]  rem;
        int          rr;
        int          g;
        logic [1:0]  expAck;
        logic [1:0]  expFull;
        logic [38:0] expBeat;
        logic        expLast;
        logic        p;
        doReset();
        busy = 1'b0; rem = 2'b00; rr = 0; cur = '0;
        for (int c = 0; c < 400; c++) begin
            flush  = ($urandom_range(0, 39) == 0);
            wb_ack = ($urandom_range(0, 3) != 0);
            for (int u = 0; u < 2; u++) begin
                setUnit(u, 1'($urandom_range(0, 1)), 3'($urandom), 2'($urandom), $urandom, $urandom);
            end
            #1;
            for (int u = 0; u < 2; u++) begin
                expFull[u] = (mq[u].size() == 4);
                expAck[u]  = rca_done[u] & ~expFull[u] & ~flush;
            end
            expBeat = '0;
            expLast = 1'b0;
            if (busy) begin
                if (rem == 2'b00) begin
                    expLast = 1'b1;
                    expBeat = mk(1'b1, cur.id, 1'b0, 1'b0, 1'b1, 32'h0);
                end else begin
                    p       = ~rem[0];
                    expLast = ($countones(rem) == 1);
                    expBeat = mk(1'b1, cur.id, p, 1'b1, expLast, p ? cur.d1 : cur.d0);
                end
            end
            checks++;
            if (rca_ack !== expAck) begin
                errors++;
                $display("[TB] FAIL rand_ack cycle %0d: got %b expected %b", c, rca_ack, expAck);
            end
            checks++;
            if (rca_fifo_full !== expFull) begin
                errors++;
                $display("[TB] FAIL rand_full cycle %0d: got %b expected %b", c, rca_fifo_full, expFull);
            end
            checks++;
            if (beat !== expBeat) begin
                errors++;
                $display("[TB] FAIL rand_beat cycle %0d: got %h expected %h", c, beat, expBeat);
            end
            if (flush) begin
                mq[0].delete();
                mq[1].delete();
                busy = 1'b0;
            end else begin
                for (int u = 0; u < 2; u++) begin
                    if (expAck[u]) begin
                        e.id   = rca_id[u*3 +: 3];
                        e.mask = rca_rd_valid[u*2 +: 2];
                        e.d0   = rca_rd[(u*2)*32 +: 32];
                        e.d1   = rca_rd[(u*2+1)*32 +: 32];
                        mq[u].push_back(e);
                    end
                end
                if (!busy || (wb_ack && expLast)) begin
                    g = -1;
                    for (int off = 0; off < 2; off++) begin
                        if (g < 0 && mq[(rr + off) % 2].size() > 0) g = (rr + off) % 2;
                    end
                    if (g >= 0) begin
                        cur  = mq[g].pop_front();
                        rem  = cur.mask;
                        busy = 1'b1;
                        rr   = (g + 1) % 2;
                    end else begin
                        busy = 1'b0;
                    end
                end else if (wb_ack) begin
                    rem = rem & (rem - 2'b01);
                end
            end
            @(negedge clk);
        end
        flush = 1'b0;
        wb_ack = 1'b0;
        rca_done = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; flush = 1'b0; wb_ack = 1'b0;
        rca_done = '0; rca_id = '0; rca_rd = '0; rca_rd_valid = '0;
        test_reset();
        test_single();
        test_masks();
        test_round_robin();
        test_full_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
